// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use bubble
// insertion, flush and hold handling for the RV64 scalar core.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [63:0] id_rs1_data,
  input  logic [63:0] id_rs2_data,
  input  logic [63:0] id_imm,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_control,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_id,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [63:0] aluin1_ex,
  output logic [63:0] aluin2_ex,
  output logic [3:0]  alu_control,
  output logic [63:0] ex_store_data
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_slot_t;

  ex_slot_t    r_ex;
  ex_slot_t    w_next;
  logic        w_hazard;
  logic [63:0] w_fwd_rs1;
  logic [63:0] w_fwd_rs2;

  // MEM is younger than WB, so it wins; x0 is hard-wired and never forwarded.
  function automatic logic [63:0] fwd(
    input logic [4:0]  idx,
    input logic [63:0] stored,
    input logic        m_we,
    input logic [4:0]  m_rd,
    input logic [63:0] m_val,
    input logic        w_we,
    input logic [4:0]  w_rd,
    input logic [63:0] w_val
  );
    if (m_we && m_rd != 5'd0 && m_rd == idx)      return m_val;
    else if (w_we && w_rd != 5'd0 && w_rd == idx) return w_val;
    else                                          return stored;
  endfunction

  assign w_hazard = id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) &&
                    ((id_use_rs1 && r_ex.rd == id_rs1) || (id_use_rs2 && r_ex.rd == id_rs2));
  // A redirect discards the ID instruction, so holding it would be pointless.
  assign stall_id = w_hazard && !flush;

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_ex;
    if (flush) begin
      w_next = '0;
    end else if (hold) begin
      w_next = r_ex;
    end else if (stall_id) begin
      w_next = '0;
    end else begin
      w_next.valid       = id_valid;
      w_next.rs1         = id_rs1;
      w_next.rs2         = id_rs2;
      w_next.rd          = id_rd;
      // Register file is written and read in the same cycle; take the write value.
      w_next.rs1_data    = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
      w_next.rs2_data    = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
      w_next.imm         = id_imm;
      w_next.alu_src     = id_alu_src;
      w_next.alu_control = id_alu_control;
      w_next.reg_write   = id_reg_write;
      w_next.mem_read    = id_mem_read;
      w_next.mem_write   = id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so all state updates see pre-edge values.
    if (!rst_n) r_ex <= '0;
    else        r_ex <= w_next;
  end

  assign w_fwd_rs1 = fwd(r_ex.rs1, r_ex.rs1_data, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_data);
  assign w_fwd_rs2 = fwd(r_ex.rs2, r_ex.rs2_data, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_data);

  assign ex_valid      = r_ex.valid;
  assign ex_rd         = r_ex.rd;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign alu_control   = r_ex.alu_control;
  assign aluin1_ex     = w_fwd_rs1;
  assign aluin2_ex     = r_ex.alu_src ? r_ex.imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a slot-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [63:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush, hold;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [63:0] aluin1_ex, aluin2_ex, ex_store_data;
  logic [3:0]  alu_control;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .aluin1_ex(aluin1_ex), .aluin2_ex(aluin2_ex),
    .alu_control(alu_control), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the instruction currently sitting in EX, as the ISA sees it.
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] v1, v2, imm;
    logic        src;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } slot_t;

  slot_t m;
  slot_t empty_slot;

  // Value of architectural register idx as the newest in-flight producer sees it.
  function automatic logic [63:0] newest(input logic [4:0] idx, input logic [63:0] stale);
    if (idx == 0) return stale;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return stale;
  endfunction

  function automatic logic model_stall();
    logic dep;
    dep = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
    return !flush && id_valid && m.valid && m.mr && m.rd != 0 && dep;
  endfunction

  function automatic slot_t model_next();
    slot_t n;
    if (flush || (!hold && model_stall())) return empty_slot;
    if (hold) return m;
    n.valid = id_valid; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
    n.v1  = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
    n.v2  = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    n.imm = id_imm; n.src = id_alu_src; n.op = id_alu_control;
    n.rw  = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
    return n;
  endfunction

  task automatic check_model();
    logic [63:0] b;
    b = newest(m.rs2, m.v2);
    check("rnd_stall", stall_id, model_stall());
    check("rnd_valid", ex_valid, m.valid);
    check("rnd_rd", ex_rd, m.rd);
    check("rnd_rw", ex_reg_write, m.rw);
    check("rnd_mr", ex_mem_read, m.mr);
    check("rnd_mw", ex_mem_write, m.mw);
    check("rnd_op", alu_control, m.op);
    check("rnd_a1", aluin1_ex, newest(m.rs1, m.v1));
    check("rnd_a2", aluin2_ex, m.src ? m.imm : b);
    check("rnd_st", ex_store_data, b);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0; id_alu_control = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0; flush = 0; hold = 0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick();
    slot_t n;
    n = model_next();
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic issue_load_x4();
    idle();
    id_valid = 1; id_rd = 5'd4; id_rs1 = 5'd1; id_use_rs1 = 1;
    id_mem_read = 1; id_reg_write = 1; id_alu_control = 4'b0010;
    tick();
  endtask

  task automatic present_user_of_x4();
    idle();
    id_valid = 1; id_rs1 = 5'd2; id_use_rs1 = 1; id_rs2 = 5'd4; id_use_rs2 = 1;
    id_rs2_data = 64'd1; id_rd = 5'd5; id_reg_write = 1; id_alu_control = 4'b0010;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [63:0] d1, d2, imm;
    logic        src;
    logic [3:0]  op;
    logic        mrw;
    logic [4:0]  mrd;
    logic [63:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [63:0] wdat;
    logic [63:0] e1, e2, est;
  } vec_t;

  vec_t vt[5];

  initial begin
    empty_slot = '{default: '0};
    m = empty_slot;
    vt[0] = '{5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 1'b0, 4'b0010,
              1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 64'd5, 64'd7, 64'd7};
    vt[1] = '{5'd3, 5'd9, 64'd0, 64'd9, 64'd0, 1'b0, 4'b0110,
              1'b1, 5'd3, 64'h100, 1'b1, 5'd3, 64'h55, 64'h100, 64'd9, 64'd9};
    vt[2] = '{5'd5, 5'd6, 64'd1, 64'd2, 64'd0, 1'b0, 4'b0111,
              1'b1, 5'd7, 64'h77, 1'b1, 5'd6, 64'h66, 64'd1, 64'h66, 64'h66};
    vt[3] = '{5'd0, 5'd8, 64'd0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 4'b0010,
              1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234};
    vt[4] = '{5'd11, 5'd10, 64'd42, 64'd3, 64'h20, 1'b1, 4'b1111,
              1'b1, 5'd10, 64'hAB, 1'b1, 5'd11, 64'hCD, 64'hCD, 64'h20, 64'hAB};

    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    sample();
    check("rst_valid", ex_valid, 0);
    check("rst_a1", aluin1_ex, 0);
    check("rst_stall", stall_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < 5; i++) begin
      idle();
      id_valid = 1; id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_rd = 5'd1;
      id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = vt[i].d1; id_rs2_data = vt[i].d2;
      id_imm = vt[i].imm; id_alu_src = vt[i].src; id_alu_control = vt[i].op; id_reg_write = 1;
      tick();
      idle();
      mem_reg_write = vt[i].mrw; mem_rd = vt[i].mrd; mem_result = vt[i].mres;
      wb_reg_write = vt[i].wrw; wb_rd = vt[i].wrd; wb_data = vt[i].wdat;
      sample();
      check($sformatf("vec%0d_valid", i), ex_valid, 1);
      check($sformatf("vec%0d_op", i), alu_control, vt[i].op);
      check($sformatf("vec%0d_a1", i), aluin1_ex, vt[i].e1);
      check($sformatf("vec%0d_a2", i), aluin2_ex, vt[i].e2);
      check($sformatf("vec%0d_st", i), ex_store_data, vt[i].est);
      tick();
    end

    // Same-cycle register-file write and read captures the written value.
    idle();
    id_valid = 1; id_rs1 = 5'd7; id_use_rs1 = 1; id_rs1_data = 64'd1;
    wb_reg_write = 1; wb_rd = 5'd7; wb_data = 64'h77;
    tick();
    idle();
    sample();
    check("bypass_a1", aluin1_ex, 64'h77);

    // Load-use: one bubble, then WB forwarding supplies the load data.
    issue_load_x4();
    present_user_of_x4();
    sample();
    check("lu_stall", stall_id, 1);
    tick();
    mem_reg_write = 1; mem_rd = 5'd4; mem_result = 64'h1111;
    sample();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_stall", stall_id, 0);
    tick();
    idle();
    wb_reg_write = 1; wb_rd = 5'd4; wb_data = 64'hDEAD;
    sample();
    check("lu_enter_valid", ex_valid, 1);
    check("lu_enter_rd", ex_rd, 5'd5);
    check("lu_enter_a2", aluin2_ex, 64'hDEAD);
    check("lu_enter_stall", stall_id, 0);
    tick();

    // Flush, hold and hazard together: flush wins, no stall.
    issue_load_x4();
    present_user_of_x4();
    flush = 1; hold = 1;
    sample();
    check("fhh_stall", stall_id, 0);
    tick();
    idle();
    sample();
    check("fhh_valid", ex_valid, 0);
    check("fhh_mr", ex_mem_read, 0);

    // Hold freezes EX while stall_id keeps evaluating; then async reset mid-hold.
    issue_load_x4();
    present_user_of_x4();
    hold = 1;
    sample();
    check("hold_stall0", stall_id, 1);
    tick();
    sample();
    check("hold_valid", ex_valid, 1);
    check("hold_mr", ex_mem_read, 1);
    check("hold_rd", ex_rd, 5'd4);
    check("hold_stall1", stall_id, 1);
    #2;
    rst_n = 0;
    #1;
    m = empty_slot;
    check("arst_valid", ex_valid, 0);
    check("arst_rd", ex_rd, 0);
    check("arst_rw", ex_reg_write, 0);
    check("arst_mr", ex_mem_read, 0);
    check("arst_op", alu_control, 0);
    check("arst_a1", aluin1_ex, 0);
    check("arst_a2", aluin2_ex, 0);
    check("arst_st", ex_store_data, 0);
    check("arst_stall", stall_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();

    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd  = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
      id_imm = {$urandom, $urandom}; id_alu_src = 1'($urandom);
      id_alu_control = 4'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom);
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7));
      mem_result = {$urandom, $urandom};
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      sample();
      check_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
